// File: rtl/rv32_pkg.sv
// rv32_pkg: RV32I opcode, immediate-format and ALU one-hot definitions shared by the decode stage
package rv32_pkg;
  localparam int RV_XLEN = 32;

  typedef enum logic [6:0] {
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111,
    OPC_BRANCH = 7'b1100011,
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_OP_IMM = 7'b0010011,
    OPC_OP     = 7'b0110011,
    OPC_FENCE  = 7'b0001111,
    OPC_SYSTEM = 7'b1110011
  } opcode_e;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_type_e;

  localparam int ALU_LUI_BIT   = 19;
  localparam int ALU_AUIPC_BIT = 18;
  localparam int ALU_JAL_BIT   = 17;
  localparam int ALU_JALR_BIT  = 16;
  localparam int ALU_BEQ_BIT   = 15;
  localparam int ALU_BNE_BIT   = 14;
  localparam int ALU_BLT_BIT   = 13;
  localparam int ALU_BGE_BIT   = 12;
  localparam int ALU_BLTU_BIT  = 11;
  localparam int ALU_BGEU_BIT  = 10;
  localparam int ALU_ADD_BIT   = 9;
  localparam int ALU_SUB_BIT   = 8;
  localparam int ALU_SLL_BIT   = 7;
  localparam int ALU_SRA_BIT   = 6;
  localparam int ALU_SRL_BIT   = 5;
  localparam int ALU_SLT_BIT   = 4;
  localparam int ALU_SLTU_BIT  = 3;
  localparam int ALU_XOR_BIT   = 2;
  localparam int ALU_OR_BIT    = 1;
  localparam int ALU_AND_BIT   = 0;

  typedef struct packed {
    logic [19:0] opcode;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] pc;
    logic [31:0] target;
    logic [4:0]  rd;
    logic        wen;
    logic        mem_rd;
    logic        mem_wr;
    logic [2:0]  funct3;
    logic [31:0] store_data;
    logic        illegal;
  } id_out_t;

  function automatic logic [19:0] oh(input int b);
    return 20'(1) << b;
  endfunction

  // alt selects sub for funct3=000 and sra for funct3=101
  function automatic logic [19:0] alu_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return oh(alt ? ALU_SUB_BIT : ALU_ADD_BIT);
      3'b001:  return oh(ALU_SLL_BIT);
      3'b010:  return oh(ALU_SLT_BIT);
      3'b011:  return oh(ALU_SLTU_BIT);
      3'b100:  return oh(ALU_XOR_BIT);
      3'b101:  return oh(alt ? ALU_SRA_BIT : ALU_SRL_BIT);
      3'b110:  return oh(ALU_OR_BIT);
      default: return oh(ALU_AND_BIT);
    endcase
  endfunction

  function automatic logic [19:0] br_f3(input logic [2:0] f3);
    case (f3)
      3'b000:  return oh(ALU_BEQ_BIT);
      3'b001:  return oh(ALU_BNE_BIT);
      3'b100:  return oh(ALU_BLT_BIT);
      3'b101:  return oh(ALU_BGE_BIT);
      3'b110:  return oh(ALU_BLTU_BIT);
      3'b111:  return oh(ALU_BGEU_BIT);
      default: return '0;
    endcase
  endfunction
endpackage

// File: rtl/imm_gen.sv
// imm_gen: extracts and sign-extends the RV32I immediate of the selected format
module imm_gen
  import rv32_pkg::*;
(
  input  logic [31:7] inst,
  input  imm_type_e   itype,
  output logic [31:0] imm
);
  // Reassemble the scattered immediate bits for the requested format
  always_comb
    imm = itype == IMM_S ? {{20{inst[31]}}, inst[31:25], inst[11:7]} :
          itype == IMM_B ? {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0} :
          itype == IMM_U ? {inst[31:12], 12'd0} :
          itype == IMM_J ? {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0} :
                           {{20{inst[31]}}, inst[31:20]};
endmodule

// File: rtl/id_stage.sv
// id_stage: registered RV32I decode with operand prep, write-back bypass, RAW scoreboard and flush
module id_stage
  import rv32_pkg::*;
#(
  parameter int XLEN = RV_XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [XLEN-1:0] if_pc,
  input  logic [31:0]     if_inst,
  output logic [4:0]      rf_raddr1,
  output logic [4:0]      rf_raddr2,
  input  logic [XLEN-1:0] rf_rdata1,
  input  logic [XLEN-1:0] rf_rdata2,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [19:0]     ex_inst_opcode,
  output logic [XLEN-1:0] ex_op1,
  output logic [XLEN-1:0] ex_op2,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_target,
  output logic [4:0]      ex_rd,
  output logic            ex_wen,
  output logic            ex_mem_rd,
  output logic            ex_mem_wr,
  output logic [2:0]      ex_funct3,
  output logic [XLEN-1:0] ex_store_data,
  output logic            ex_illegal
);
  opcode_e     opc;
  imm_type_e   itype;
  logic [31:0] imm, rs1_val, rs2_val, busy, busy_n;
  logic [4:0]  rs1, rs2, rd;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        use1, use2, wr, ill, clr1, clr2, haz1, haz2, load;
  id_out_t     d, q;

  assign opc = opcode_e'(if_inst[6:0]);
  assign rd  = if_inst[11:7];
  assign f3  = if_inst[14:12];
  assign rs1 = if_inst[19:15];
  assign rs2 = if_inst[24:20];
  assign f7  = if_inst[31:25];
  assign rf_raddr1 = rs1;
  assign rf_raddr2 = rs2;

  assign itype = (opc == OPC_LUI || opc == OPC_AUIPC) ? IMM_U :
                 opc == OPC_JAL    ? IMM_J :
                 opc == OPC_BRANCH ? IMM_B :
                 opc == OPC_STORE  ? IMM_S : IMM_I;

  imm_gen u_imm (.inst(if_inst[31:7]), .itype(itype), .imm(imm));

  assign clr1 = wb_valid && wb_rd == rs1;
  assign clr2 = wb_valid && wb_rd == rs2;
  assign rs1_val = rs1 == 5'd0 ? '0 : clr1 ? wb_data : rf_rdata1;
  assign rs2_val = rs2 == 5'd0 ? '0 : clr2 ? wb_data : rf_rdata2;

  // Decode the instruction into ALU one-hot, operands and side fields
  always_comb begin
    d = '0;
    d.pc = if_pc;
    d.funct3 = f3;
    d.store_data = rs2_val;
    use1 = 1'b0;
    use2 = 1'b0;
    wr = 1'b0;
    ill = 1'b0;
    case (opc)
      OPC_LUI:    begin d.opcode = oh(ALU_LUI_BIT); d.op2 = imm; wr = 1'b1; end
      OPC_AUIPC:  begin d.opcode = oh(ALU_AUIPC_BIT); d.op1 = if_pc; d.op2 = imm; wr = 1'b1; end
      OPC_JAL:    begin d.opcode = oh(ALU_JAL_BIT); d.op1 = if_pc; d.target = if_pc + imm; wr = 1'b1; end
      OPC_JALR:   begin d.opcode = oh(ALU_JALR_BIT); d.op1 = if_pc; d.target = (rs1_val + imm) & ~32'd1; wr = 1'b1; use1 = 1'b1; ill = f3 != 3'b000; end
      OPC_BRANCH: begin d.opcode = br_f3(f3); d.op1 = rs1_val; d.op2 = rs2_val; d.target = if_pc + imm; use1 = 1'b1; use2 = 1'b1; ill = f3[2:1] == 2'b01; end
      OPC_LOAD:   begin d.opcode = oh(ALU_ADD_BIT); d.op1 = rs1_val; d.op2 = imm; d.mem_rd = 1'b1; wr = 1'b1; use1 = 1'b1; ill = f3 == 3'b011 || f3[2:1] == 2'b11; end
      OPC_STORE:  begin d.opcode = oh(ALU_ADD_BIT); d.op1 = rs1_val; d.op2 = imm; d.mem_wr = 1'b1; use1 = 1'b1; use2 = 1'b1; ill = f3[2] || f3 == 3'b011; end
      OPC_OP_IMM: begin
        d.opcode = alu_f3(f3, f3 == 3'b101 && f7[5]);
        d.op1 = rs1_val;
        d.op2 = f3[1:0] == 2'b01 ? {27'd0, rs2} : imm;
        wr = 1'b1;
        use1 = 1'b1;
        ill = (f3 == 3'b001 && f7 != 7'd0) || (f3 == 3'b101 && {f7[6], f7[4:0]} != 6'd0);
      end
      OPC_OP:     begin
        d.opcode = alu_f3(f3, f7[5]);
        d.op1 = rs1_val;
        d.op2 = f3[1:0] == 2'b01 ? {27'd0, rs2_val[4:0]} : rs2_val;
        wr = 1'b1;
        use1 = 1'b1;
        use2 = 1'b1;
        ill = !(f7 == 7'd0 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101)));
      end
      OPC_FENCE:  ill = 1'b0;
      default:    ill = 1'b1;
    endcase
    if (ill) begin
      d.opcode = '0;
      d.mem_rd = 1'b0;
      d.mem_wr = 1'b0;
      wr = 1'b0;
      use1 = 1'b0;
      use2 = 1'b0;
    end
    d.wen = wr && rd != 5'd0;
    d.rd = d.wen ? rd : 5'd0;
    d.illegal = ill;
  end

  // A source is blocked by a pending busy bit or by the writer still sitting in the output register
  assign haz1 = use1 && rs1 != 5'd0 && ((busy[rs1] && !clr1) || (ex_valid && q.wen && q.rd == rs1));
  assign haz2 = use2 && rs2 != 5'd0 && ((busy[rs2] && !clr2) || (ex_valid && q.wen && q.rd == rs2));
  assign if_ready = !(haz1 || haz2) && (!ex_valid || ex_ready);
  assign load = if_valid && if_ready && !flush;

  // Scoreboard update: clear on write-back, then set on issue to EX so a same-rd set wins
  always_comb begin
    busy_n = busy;
    if (wb_valid) busy_n[wb_rd] = 1'b0;
    if (ex_valid && ex_ready && q.wen && !flush) busy_n[q.rd] = 1'b1;
    busy_n[0] = 1'b0;
  end

  // Scoreboard register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) busy <= '0;
    else busy <= busy_n;

  // Output register: flush kills, new instruction loads, accepted instruction retires, else hold
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      q <= '0;
      ex_valid <= 1'b0;
    end else if (flush) ex_valid <= 1'b0;
    else if (load) begin
      q <= d;
      ex_valid <= 1'b1;
    end else if (ex_ready) ex_valid <= 1'b0;

  assign ex_inst_opcode = q.opcode;
  assign ex_op1 = q.op1;
  assign ex_op2 = q.op2;
  assign ex_pc = q.pc;
  assign ex_target = q.target;
  assign ex_rd = q.rd;
  assign ex_wen = q.wen;
  assign ex_mem_rd = q.mem_rd;
  assign ex_mem_wr = q.mem_wr;
  assign ex_funct3 = q.funct3;
  assign ex_store_data = q.store_data;
  assign ex_illegal = q.illegal;
endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed self-checking bench for the RV32I decode stage
module tb_id_stage;
  logic clk = 1'b0, rst_n = 1'b0;
  logic if_valid, if_ready, wb_valid, flush, ex_valid, ex_ready, ex_wen, ex_mem_rd, ex_mem_wr, ex_illegal;
  logic [31:0] if_pc, if_inst, rf_rdata1, rf_rdata2, wb_data;
  logic [31:0] ex_op1, ex_op2, ex_pc, ex_target, ex_store_data;
  logic [4:0] rf_raddr1, rf_raddr2, wb_rd, ex_rd;
  logic [19:0] ex_inst_opcode;
  logic [2:0] ex_funct3;
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  id_stage dut (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_inst(if_inst),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_inst_opcode(ex_inst_opcode), .ex_op1(ex_op1), .ex_op2(ex_op2),
    .ex_pc(ex_pc), .ex_target(ex_target), .ex_rd(ex_rd), .ex_wen(ex_wen), .ex_mem_rd(ex_mem_rd),
    .ex_mem_wr(ex_mem_wr), .ex_funct3(ex_funct3), .ex_store_data(ex_store_data), .ex_illegal(ex_illegal)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    if_valid = 0; if_pc = 0; if_inst = 0; rf_rdata1 = 0; rf_rdata2 = 0;
    wb_valid = 0; wb_rd = 0; wb_data = 0; flush = 0; ex_ready = 1;
    step; step;
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", ex_valid); end
    checks++; if (ex_inst_opcode !== 20'h0) begin errors++; $display("FAIL reset_opcode: got %h want 0", ex_inst_opcode); end
    checks++; if (ex_op2 !== 32'h0 || ex_rd !== 5'd0) begin errors++; $display("FAIL reset_fields: op2 %h rd %0d want 0", ex_op2, ex_rd); end
    checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL reset_if_ready: got %b want 1", if_ready); end
    rst_n = 1;
    step;
  endtask

  task automatic test_addi;
    if_valid = 1; if_inst = 32'h00500093; if_pc = 32'h100; rf_rdata1 = 32'hDEAD; rf_rdata2 = 0;
    #1;
    checks++; if (rf_raddr1 !== 5'd0 || rf_raddr2 !== 5'd5) begin errors++; $display("FAIL addi_raddr: got %0d/%0d want 0/5", rf_raddr1, rf_raddr2); end
    step;
    if_inst = 32'h00208233;
    #1;
    checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL addi_valid: got %b want 1", ex_valid); end
    checks++; if (ex_inst_opcode !== 20'h00200) begin errors++; $display("FAIL addi_opcode: got %h want 00200", ex_inst_opcode); end
    checks++; if (ex_op1 !== 32'h0 || ex_op2 !== 32'h5) begin errors++; $display("FAIL addi_ops: got %h/%h want 0/5", ex_op1, ex_op2); end
    checks++; if (ex_rd !== 5'd1 || ex_wen !== 1'b1 || ex_pc !== 32'h100) begin errors++; $display("FAIL addi_rd: rd %0d wen %b pc %h want 1 1 100", ex_rd, ex_wen, ex_pc); end
    checks++; if (if_ready !== 1'b0) begin errors++; $display("FAIL raw_exreg_stall: got %b want 0", if_ready); end
  endtask

  task automatic test_raw_stall;
    rf_rdata1 = 32'h1111; rf_rdata2 = 32'h7;
    step;
    checks++; if (if_ready !== 1'b0 || ex_valid !== 1'b0) begin errors++; $display("FAIL raw_busy_stall: if_ready %b ex_valid %b want 0 0", if_ready, ex_valid); end
    step;
    checks++; if (if_ready !== 1'b0) begin errors++; $display("FAIL raw_busy_stall2: got %b want 0", if_ready); end
    wb_valid = 1; wb_rd = 1; wb_data = 32'h55;
    #1;
    checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL raw_wb_release: got %b want 1", if_ready); end
    step;
    wb_valid = 0; if_valid = 0;
    checks++; if (ex_valid !== 1'b1 || ex_inst_opcode !== 20'h00200) begin errors++; $display("FAIL raw_add: valid %b opcode %h want 1 00200", ex_valid, ex_inst_opcode); end
    checks++; if (ex_op1 !== 32'h55 || ex_op2 !== 32'h7 || ex_rd !== 5'd4) begin errors++; $display("FAIL raw_add_ops: %h/%h rd %0d want 55/7 rd 4", ex_op1, ex_op2, ex_rd); end
  endtask

  task automatic test_set_wins;
    wb_valid = 1; wb_rd = 4; wb_data = 32'h0;
    step;
    wb_valid = 0;
    if_valid = 1; if_inst = 32'h00120293; rf_rdata1 = 32'h3333;
    #1;
    checks++; if (if_ready !== 1'b0) begin errors++; $display("FAIL set_wins_stall: got %b want 0", if_ready); end
    wb_valid = 1; wb_rd = 4; wb_data = 32'h99;
    #1;
    checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL set_wins_release: got %b want 1", if_ready); end
    step;
    wb_valid = 0; if_valid = 0;
    checks++; if (ex_op1 !== 32'h99 || ex_op2 !== 32'h1 || ex_rd !== 5'd5) begin errors++; $display("FAIL bypass_addi: %h/%h rd %0d want 99/1 rd 5", ex_op1, ex_op2, ex_rd); end
  endtask

  task automatic test_srai_lui;
    if_valid = 1; if_inst = 32'h4030D113; if_pc = 32'h200; rf_rdata1 = 32'h80000000;
    step;
    checks++; if (ex_inst_opcode !== 20'h00040) begin errors++; $display("FAIL srai_opcode: got %h want 00040", ex_inst_opcode); end
    checks++; if (ex_op1 !== 32'h80000000 || ex_op2 !== 32'h3 || ex_rd !== 5'd2) begin errors++; $display("FAIL srai_ops: %h/%h rd %0d want 80000000/3 rd 2", ex_op1, ex_op2, ex_rd); end
    if_inst = 32'h123451B7; if_pc = 32'h204;
    step;
    checks++; if (ex_inst_opcode !== 20'h80000 || ex_op2 !== 32'h12345000) begin errors++; $display("FAIL lui: opcode %h op2 %h want 80000 12345000", ex_inst_opcode, ex_op2); end
    checks++; if (ex_wen !== 1'b1 || ex_rd !== 5'd3 || ex_op1 !== 32'h0 || ex_pc !== 32'h204) begin errors++; $display("FAIL lui_fields: wen %b rd %0d op1 %h pc %h", ex_wen, ex_rd, ex_op1, ex_pc); end
  endtask

  task automatic test_hold;
    ex_ready = 0; if_inst = 32'h00000013;
    #1;
    checks++; if (if_ready !== 1'b0) begin errors++; $display("FAIL hold_if_ready: got %b want 0", if_ready); end
    step; step;
    checks++; if (ex_valid !== 1'b1 || ex_op2 !== 32'h12345000 || ex_rd !== 5'd3) begin errors++; $display("FAIL hold_stable: valid %b op2 %h rd %0d", ex_valid, ex_op2, ex_rd); end
  endtask

  task automatic test_flush;
    if_inst = 32'h00700513; flush = 1;
    step;
    flush = 0;
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", ex_valid); end
    ex_ready = 1; if_inst = 32'h00A185B3; rf_rdata1 = 32'h30; rf_rdata2 = 32'h40;
    #1;
    checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL flush_no_busy: got %b want 1", if_ready); end
    step;
    checks++; if (ex_valid !== 1'b1 || ex_inst_opcode !== 20'h00200 || ex_rd !== 5'd11) begin errors++; $display("FAIL post_flush: valid %b opcode %h rd %0d", ex_valid, ex_inst_opcode, ex_rd); end
    checks++; if (ex_op1 !== 32'h30 || ex_op2 !== 32'h40) begin errors++; $display("FAIL post_flush_ops: %h/%h want 30/40", ex_op1, ex_op2); end
  endtask

  task automatic test_store_branch;
    if_inst = 32'h0063A623; rf_rdata1 = 32'h1000; rf_rdata2 = 32'hCAFE;
    step;
    checks++; if (ex_inst_opcode !== 20'h00200 || ex_op1 !== 32'h1000 || ex_op2 !== 32'd12) begin errors++; $display("FAIL store_ops: opcode %h %h/%h", ex_inst_opcode, ex_op1, ex_op2); end
    checks++; if (ex_mem_wr !== 1'b1 || ex_mem_rd !== 1'b0 || ex_wen !== 1'b0 || ex_store_data !== 32'hCAFE || ex_funct3 !== 3'd2) begin errors++; $display("FAIL store_side: wr %b rd %b wen %b sd %h f3 %0d", ex_mem_wr, ex_mem_rd, ex_wen, ex_store_data, ex_funct3); end
    if_inst = 32'hFE001CE3; if_pc = 32'h300; rf_rdata1 = 32'h11; rf_rdata2 = 32'h22;
    step;
    checks++; if (ex_inst_opcode !== 20'h04000 || ex_target !== 32'h2F8) begin errors++; $display("FAIL bne: opcode %h target %h want 04000 2f8", ex_inst_opcode, ex_target); end
    checks++; if (ex_op1 !== 32'h0 || ex_op2 !== 32'h0 || ex_wen !== 1'b0) begin errors++; $display("FAIL bne_x0: %h/%h wen %b want 0/0/0", ex_op1, ex_op2, ex_wen); end
  endtask

  task automatic test_illegal;
    if_inst = 32'hFFFFFFFF;
    step;
    checks++; if (ex_valid !== 1'b1 || ex_inst_opcode !== 20'h0 || ex_illegal !== 1'b1) begin errors++; $display("FAIL illegal: valid %b opcode %h ill %b", ex_valid, ex_inst_opcode, ex_illegal); end
    checks++; if (ex_wen !== 1'b0 || ex_mem_rd !== 1'b0 || ex_mem_wr !== 1'b0) begin errors++; $display("FAIL illegal_side: wen %b mrd %b mwr %b want 0", ex_wen, ex_mem_rd, ex_mem_wr); end
  endtask

  task automatic test_reset_mid_stall;
    if_inst = 32'h00028233;
    #1;
    checks++; if (if_ready !== 1'b0) begin errors++; $display("FAIL midstall_stall: got %b want 0", if_ready); end
    rst_n = 0;
    #1;
    checks++; if (ex_valid !== 1'b0 || ex_illegal !== 1'b0 || if_ready !== 1'b1) begin errors++; $display("FAIL midstall_reset: valid %b ill %b if_ready %b", ex_valid, ex_illegal, if_ready); end
    if_valid = 0;
    step;
  endtask

  initial begin
    test_reset;
    test_addi;
    test_raw_stall;
    test_set_wins;
    test_srai_lui;
    test_hold;
    test_flush;
    test_store_branch;
    test_illegal;
    test_reset_mid_stall;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
